// File: rtl/fpu_result_uart_tx.sv
`default_nettype none
// ============================================================================
// Module      : fpu_result_uart_tx
// Description : Sends 16-bit FPU results to the host as two 8N1 UART frames,
//               high byte first. Shares the runtime baud divisor with the RX.
//               Define FPU_UART_TX_FIFO_EN for a FIFO_DEPTH-entry result FIFO;
//               otherwise a single holding register buffers one result.
// Revision    : 1.0 - initial release
// ============================================================================
module fpu_result_uart_tx #(
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst_l,
    input  logic [15:0] CLKS_PER_BIT,
    input  logic [15:0] i_result,
    input  logic        i_result_valid,
    output logic        o_Tx_Serial,
    output logic        o_Tx_Active,
    output logic        o_Tx_Done,
    output logic        o_overflow
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } state_t;

    state_t      r_state;
    logic [15:0] r_shift;
    logic [15:0] r_clks;
    logic [15:0] r_timer;
    logic [2:0]  r_bit_idx;
    logic        r_byte_sel;

    logic        w_empty;
    logic        w_full;
    logic        w_pop;
    logic        w_push_ok;
    logic [15:0] w_head;
    logic [7:0]  w_cur_byte;
    logic [2:0]  w_next_idx;
    logic        w_bit_end;

    assign w_pop      = (r_state == ST_IDLE) && !w_empty;
    assign w_push_ok  = i_result_valid && (!w_full || w_pop);
    assign w_cur_byte = r_byte_sel ? r_shift[7:0] : r_shift[15:8];
    assign w_next_idx = r_bit_idx + 3'd1;
    assign w_bit_end  = (r_timer == (r_clks - 16'd1));

`ifdef FPU_UART_TX_FIFO_EN
    localparam int c_ptr_w = $clog2(FIFO_DEPTH);

    logic [15:0]      r_mem [FIFO_DEPTH];
    logic [c_ptr_w:0] r_wr_ptr;
    logic [c_ptr_w:0] r_rd_ptr;

    // Extra pointer MSB separates full (MSBs differ) from empty (all equal).
    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_full  = (r_wr_ptr[c_ptr_w] != r_rd_ptr[c_ptr_w]) &&
                     (r_wr_ptr[c_ptr_w-1:0] == r_rd_ptr[c_ptr_w-1:0]);
    assign w_head  = r_mem[r_rd_ptr[c_ptr_w-1:0]];

    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_mem[r_wr_ptr[c_ptr_w-1:0]] <= i_result;
        end
    end

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
        end
    end
`else
    logic [15:0] r_hold;
    logic        r_hold_valid;

    assign w_empty = !r_hold_valid;
    assign w_full  = r_hold_valid;
    assign w_head  = r_hold;

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            r_hold       <= 16'd0;
            r_hold_valid <= 1'b0;
        end else if (w_push_ok) begin
            r_hold       <= i_result;
            r_hold_valid <= 1'b1;
        end else if (w_pop) begin
            r_hold_valid <= 1'b0;
        end
    end
`endif

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            o_overflow <= 1'b0;
        end else begin
            o_overflow <= i_result_valid && !w_push_ok;
        end
    end

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            r_state     <= ST_IDLE;
            r_shift     <= 16'd0;
            r_clks      <= 16'd1;
            r_timer     <= 16'd0;
            r_bit_idx   <= 3'd0;
            r_byte_sel  <= 1'b0;
            o_Tx_Serial <= 1'b1;
            o_Tx_Active <= 1'b0;
            o_Tx_Done   <= 1'b0;
        end else begin
            o_Tx_Done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    o_Tx_Serial <= 1'b1;
                    o_Tx_Active <= 1'b0;
                    if (w_pop) begin
                        r_shift     <= w_head;
                        // Divisor is frozen per word; zero behaves as one.
                        r_clks      <= (CLKS_PER_BIT == 16'd0) ? 16'd1 : CLKS_PER_BIT;
                        r_timer     <= 16'd0;
                        r_byte_sel  <= 1'b0;
                        o_Tx_Serial <= 1'b0;
                        o_Tx_Active <= 1'b1;
                        r_state     <= ST_START;
                    end
                end
                ST_START: begin
                    if (w_bit_end) begin
                        r_timer     <= 16'd0;
                        r_bit_idx   <= 3'd0;
                        o_Tx_Serial <= w_cur_byte[0];
                        r_state     <= ST_DATA;
                    end else begin
                        r_timer <= r_timer + 16'd1;
                    end
                end
                ST_DATA: begin
                    if (w_bit_end) begin
                        r_timer <= 16'd0;
                        if (r_bit_idx == 3'd7) begin
                            o_Tx_Serial <= 1'b1;
                            r_state     <= ST_STOP;
                        end else begin
                            r_bit_idx   <= w_next_idx;
                            o_Tx_Serial <= w_cur_byte[w_next_idx];
                        end
                    end else begin
                        r_timer <= r_timer + 16'd1;
                    end
                end
                ST_STOP: begin
                    if (w_bit_end) begin
                        r_timer <= 16'd0;
                        if (!r_byte_sel) begin
                            // Low byte follows immediately with no idle gap.
                            r_byte_sel  <= 1'b1;
                            o_Tx_Serial <= 1'b0;
                            r_state     <= ST_START;
                        end else begin
                            o_Tx_Active <= 1'b0;
                            o_Tx_Done   <= 1'b1;
                            r_state     <= ST_IDLE;
                        end
                    end else begin
                        r_timer <= r_timer + 16'd1;
                    end
                end
                default: begin
                    o_Tx_Serial <= 1'b1;
                    o_Tx_Active <= 1'b0;
                    r_state     <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
